im_bus_arbiter: RTL and testbench

//  Shares the single image-memory port (IM_A/IM_D/IM_WEN, IM_Q) between three requesters:
//  R0 = control/header reader, R1 = scaling pixel writer, R2 = clock-overlay (CR) writer.

---
 rtl/im_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_im_bus_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/im_bus_arbiter.sv
// Image-memory port arbiter: R0 fixed top priority, R1/R2 round-robin, burst lock, optional owner-change gap.
// Optional anti-starvation promotion is enabled by defining STARVE_GUARD_EN.
module im_bus_arbiter #(
    parameter int AW       = 20,
    parameter int DW       = 24,
    parameter int GAP_CYC  = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [2:0]    lock,
    input  logic [2:0]    wen_r,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    gnt,
    output logic [2:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] IM_A,
    output logic [DW-1:0] IM_D,
    output logic          IM_WEN,
    input  logic [DW-1:0] IM_Q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [2:0] rvalid_q, rvalid_d;
    logic       rr_ptr_q, rr_ptr_d;   // 0: R1 preferred, 1: R2 preferred
    logic [2:0] starve_s;
    logic [2:0] win_s;
    logic [2:0] others_s;
    logic       own_req_s;
    logic       own_lock_s;
    logic       brk_s;

    function automatic logic [2:0] arb_pick(input logic [2:0] r, input logic ptr, input logic [2:0] st);
        logic [2:0] s;
        s = r & st;
        if (s[0])                 arb_pick = 3'b001;
        else if (s[1])            arb_pick = 3'b010;
        else if (s[2])            arb_pick = 3'b100;
        else if (r[0])            arb_pick = 3'b001;
        else if (r[1] && r[2])    arb_pick = ptr ? 3'b100 : 3'b010;
        else if (r[1])            arb_pick = 3'b010;
        else if (r[2])            arb_pick = 3'b100;
        else                      arb_pick = 3'b000;
    endfunction

`ifdef STARVE_GUARD_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    logic [2:0][3:0] wait_q, wait_d;

    // Per-requester wait counters: count while requesting without grant, saturate at the limit.
    always_comb begin
        wait_d   = wait_q;
        starve_s = 3'b000;
        for (int r = 0; r < 3; r++) begin
            if (req[r] && !gnt_q[r]) begin
                wait_d[r] = (wait_q[r] == WAIT_LIM) ? wait_q[r] : wait_q[r] + 4'd1;
            end else begin
                wait_d[r] = 4'd0;
            end
            starve_s[r] = req[r] && (wait_q[r] == WAIT_LIM);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign starve_s = 3'b000;
`endif

    assign others_s   = req & ~gnt_q;
    assign own_req_s  = |(req & gnt_q);
    assign own_lock_s = |(lock & gnt_q);
    assign brk_s      = |(starve_s & others_s);
    assign win_s      = arb_pick(req, rr_ptr_q, starve_s);

    // Next-state, next-grant and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_s != 3'b000) begin
                    state_d = ST_OWN;
                    gnt_d   = win_s;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 3'b000;
                end
            end
            ST_OWN: begin
                if (own_req_s && !brk_s && (own_lock_s || (others_s == 3'b000))) begin
                    gnt_d = gnt_q;
                end else if (win_s == 3'b000) begin
                    state_d = ST_IDLE;
                    gnt_d   = 3'b000;
                end else if (win_s == gnt_q) begin
                    gnt_d = gnt_q;
                end else if (GAP_CYC != 0) begin
                    state_d = ST_GAP;
                    gnt_d   = 3'b000;
                end else begin
                    gnt_d = win_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
        // Pointer flips away from whichever of R1/R2 is granted.
        if (gnt_d[1]) begin
            rr_ptr_d = 1'b1;
        end else if (gnt_d[2]) begin
            rr_ptr_d = 1'b0;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    assign rvalid_d = gnt_q & wen_r;

    // Arbiter state, grant and read-valid registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 3'b000;
            rvalid_q <= 3'b000;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Memory port mux driven by the registered grant; idle drives no write.
    always_comb begin
        IM_A   = {AW{1'b0}};
        IM_D   = {DW{1'b0}};
        IM_WEN = 1'b1;
        case (gnt_q)
            3'b001: begin IM_A = addr0; IM_D = wdata0; IM_WEN = wen_r[0]; end
            3'b010: begin IM_A = addr1; IM_D = wdata1; IM_WEN = wen_r[1]; end
            3'b100: begin IM_A = addr2; IM_D = wdata2; IM_WEN = wen_r[2]; end
            default: begin IM_A = {AW{1'b0}}; IM_D = {DW{1'b0}}; IM_WEN = 1'b1; end
        endcase
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = IM_Q;

endmodule

// File: tb/tb_im_bus_arbiter.sv
// Directed bench for im_bus_arbiter: vector table plus sequences for gap, round-robin, lock, starvation, reset.
module tb_im_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000, lock = 3'b000, wen_r = 3'b111;
    logic [19:0] addr0 = 20'h00040, addr1 = 20'h00100, addr2 = 20'h00200;
    logic [23:0] wdata0 = 24'h111111, wdata1 = 24'hABCDEF, wdata2 = 24'h222222;
    logic [2:0]  gnt, rvalid;
    logic [23:0] rdata, IM_D, IM_Q;
    logic [19:0] IM_A;
    logic        IM_WEN;
    int checks = 0;
    int errors = 0;

    im_bus_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wen_r(wen_r),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .IM_A(IM_A), .IM_D(IM_D), .IM_WEN(IM_WEN), .IM_Q(IM_Q)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_f(input logic [19:0] a);
        mem_f = {4'h0, a} ^ 24'hC3A55A;
    endfunction

    // Memory model: read data one cycle after address.
    always @(posedge clk) IM_Q <= mem_f(IM_A);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 3'b000; lock = 3'b000; wen_r = 3'b111;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  req, lock, wen, gnt, rv;
        logic        im_wen;
        logic [19:0] a;
        logic [23:0] d;
        logic        chk_q;
    } vec_t;

    vec_t tv[11];
    logic [2:0] exp_seq[7];
    int first_r1;

    initial begin
        tv[0]  = '{3'b010, 3'b000, 3'b101, 3'b010, 3'b000, 1'b0, 20'h00100, 24'hABCDEF, 1'b0};
        tv[1]  = '{3'b010, 3'b000, 3'b101, 3'b010, 3'b000, 1'b0, 20'h00100, 24'hABCDEF, 1'b0};
        tv[2]  = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 1'b1, 20'h00000, 24'h000000, 1'b0};
        tv[3]  = '{3'b001, 3'b000, 3'b111, 3'b001, 3'b000, 1'b1, 20'h00040, 24'h111111, 1'b0};
        tv[4]  = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b001, 1'b1, 20'h00000, 24'h000000, 1'b1};
        tv[5]  = '{3'b100, 3'b000, 3'b011, 3'b100, 3'b000, 1'b0, 20'h00200, 24'h222222, 1'b0};
        tv[6]  = '{3'b101, 3'b000, 3'b011, 3'b000, 3'b000, 1'b1, 20'h00000, 24'h000000, 1'b0};
        tv[7]  = '{3'b101, 3'b000, 3'b011, 3'b001, 3'b000, 1'b1, 20'h00040, 24'h111111, 1'b0};
        tv[8]  = '{3'b100, 3'b000, 3'b011, 3'b000, 3'b001, 1'b1, 20'h00000, 24'h000000, 1'b1};
        tv[9]  = '{3'b100, 3'b000, 3'b011, 3'b100, 3'b000, 1'b0, 20'h00200, 24'h222222, 1'b0};
        tv[10] = '{3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b1, 20'h00000, 24'h000000, 1'b0};

        // Reset state while reset is held.
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_wen", 32'(IM_WEN), 32'd1);
        chk("rst_addr", 32'(IM_A), 32'd0);
        @(negedge clk); reset = 1'b0;

        // Table: inputs applied before an edge, outputs checked just after it.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req = tv[i].req; lock = tv[i].lock; wen_r = tv[i].wen;
            tick();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
            chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tv[i].rv));
            chk($sformatf("v%0d_wen", i), 32'(IM_WEN), 32'(tv[i].im_wen));
            chk($sformatf("v%0d_addr", i), 32'(IM_A), 32'(tv[i].a));
            chk($sformatf("v%0d_data", i), 32'(IM_D), 32'(tv[i].d));
            if (tv[i].chk_q) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(mem_f(20'h00040)));
        end

        // All three request at once; each drops its request once served.
        do_reset();
        exp_seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000};
        @(negedge clk); req = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("all3_%0d", i), 32'(gnt), 32'(exp_seq[i]));
            req = req & ~gnt;
        end

        // R1 and R2 held continuously alternate with a gap between owners.
        do_reset();
        exp_seq = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100};
        @(negedge clk); req = 3'b110;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("rr_%0d", i), 32'(gnt), 32'(exp_seq[i]));
        end

        // R2 locked burst holds off R0; R0 follows one gap after the lock drops.
        do_reset();
        @(negedge clk); req = 3'b100; lock = 3'b100; wen_r = 3'b011;
        tick();
        chk("lock_start", 32'(gnt), 32'b100);
        req = 3'b101;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("lock_hold_%0d", i), 32'(gnt), 32'b100);
        end
        lock = 3'b000;
        tick();
        chk("lock_gap", 32'(gnt), 32'b000);
        req = 3'b001;
        tick();
        chk("lock_r0", 32'(gnt), 32'b001);
        tick();
        chk("burst_rvalid", 32'(rvalid), 32'b001);
        // Asynchronous reset in the middle of R0's burst.
        reset = 1'b1;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_wen", 32'(IM_WEN), 32'd1);
        chk("midrst_addr", 32'(IM_A), 32'd0);
        @(negedge clk); reset = 1'b0;

        // R0 locked forever while R1 waits.
        do_reset();
        @(negedge clk); req = 3'b001; lock = 3'b001;
        tick();
        chk("starve_r0", 32'(gnt), 32'b001);
        req = 3'b011;
        first_r1 = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (gnt == 3'b010 && first_r1 == 0) first_r1 = c;
        end
`ifdef STARVE_GUARD_EN
        // 15 counted waits, one release edge into the gap, then the grant edge.
        chk("starve_promote", 32'((first_r1 >= 16) && (first_r1 <= 18)), 32'd1);
`else
        chk("starve_never", 32'(first_r1), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
